// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and SRAM bus widths for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES, flags the final count; cleared on phase entry.
// Latency: last is combinational from the count; no backpressure.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic last
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign last = (cnt == 4'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two 16-bit SRAM accesses of WAIT_CYCLES+1 cycles each.
// Latency: 2*WAIT_CYCLES+3 cycles from request to DONE; ready low stalls the pipeline meanwhile.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    input  logic [SRAM_DW-1:0]  sram_dq_i,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    logic [1:0]  state;
    logic        is_write;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        req;
    logic        active;
    logic        last;
    logic [31:0] off;
    logic        unused_off;

    assign req        = mem_read | mem_write;
    assign active     = (state == S_LO) || (state == S_HI);
    assign off        = address - BASE_ADDR;
    assign unused_off = ^{off[31:19], off[1:0]};

    // Clearing whenever not in a phase, or on the final count, restarts the count at each phase entry.
    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (!active || last),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            is_write <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        word_q   <= off[18:2];
                        wdata_q  <= write_data;
                        is_write <= mem_write;
                        state    <= S_LO;
                    end
                end
                S_LO: begin
                    if (last) begin
                        if (!is_write) rdata_q[15:0] <= sram_dq_i;
                        state <= S_HI;
                    end
                end
                S_HI: begin
                    if (last) begin
                        if (!is_write) rdata_q[31:16] <= sram_dq_i;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // SRAM pins decode only from registered state, so reset forces them idle without a clock.
    assign sram_addr  = active ? {word_q, (state == S_HI)} : '0;
    assign sram_dq_o  = (active && is_write) ? ((state == S_HI) ? wdata_q[31:16] : wdata_q[15:0]) : '0;
    assign sram_dq_oe = active && is_write;
    assign sram_we_n  = !(active && is_write && !last);

    assign read_data  = ((state == S_DONE) && !is_write) ? rdata_q : '0;
    assign ready      = !(active || ((state == S_IDLE) && req));

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table on a W=1 instance, hand sequences on W=1 and W=2 instances.
module tb_sram_controller;

    logic        clk;
    logic        rst;

    logic        mr1, mw1, rdy1, oe1, we_n1;
    logic [31:0] a1, wd1, rd1;
    logic [17:0] sa1;
    logic [15:0] dq_o1, dq_i1;

    logic        mr2, mw2, rdy2, oe2, we_n2;
    logic [31:0] a2, wd2, rd2;
    logic [17:0] sa2;
    logic [15:0] dq_o2, dq_i2;

    logic [15:0] mem1 [0:63];
    logic [15:0] mem2 [0:63];

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic        tog;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [17:0] exp_a0;
        logic [17:0] exp_a1;
        int          exp_we;
        int          exp_oe;
    } vec_t;

    vec_t vecs[10];

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(mr1), .mem_write(mw1), .address(a1),
        .write_data(wd1), .read_data(rd1), .ready(rdy1), .sram_addr(sa1),
        .sram_dq_o(dq_o1), .sram_dq_i(dq_i1), .sram_dq_oe(oe1), .sram_we_n(we_n1)
    );

    sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut2 (
        .clk(clk), .rst(rst), .mem_read(mr2), .mem_write(mw2), .address(a2),
        .write_data(wd2), .read_data(rd2), .ready(rdy2), .sram_addr(sa2),
        .sram_dq_o(dq_o2), .sram_dq_i(dq_i2), .sram_dq_oe(oe2), .sram_we_n(we_n2)
    );

    always #5 clk = ~clk;

    // Behavioural SRAMs: write while strobe low, combinational read.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem1[i] <= 16'h0000;
            mem1[0] <= 16'h1111;
            mem1[1] <= 16'h2222;
            mem1[2] <= 16'h5678;
            mem1[3] <= 16'h1234;
        end else if (!we_n1 && oe1) begin
            mem1[sa1[5:0]] <= dq_o1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem2[i] <= 16'h0000;
        end else if (!we_n2 && oe2) begin
            mem2[sa2[5:0]] <= dq_o2;
        end
    end

    assign dq_i1 = mem1[sa1[5:0]];
    assign dq_i2 = mem2[sa2[5:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic run1(input string tag, input vec_t v);
        int          cyc;
        int          we_lo;
        int          oe_c;
        logic [17:0] a0;
        logic [17:0] alast;
        logic [31:0] want;
        @(negedge clk);
        mr1 = v.rd; mw1 = v.wr; a1 = v.addr; wd1 = v.wd;
        exp_q.push_back(v.exp_rd);
        #1;
        cyc = 0; we_lo = 0; oe_c = 0; a0 = '0; alast = '0;
        while (!rdy1 && cyc < 50) begin
            if (cyc == 1) a0 = sa1;
            if (cyc >= 1) alast = sa1;
            if (!we_n1) we_lo++;
            if (oe1) oe_c++;
            cyc++;
            @(negedge clk);
            #1;
            if (v.tog) begin
                mr1 = ~mr1;
                mw1 = 1'($urandom_range(0, 1));
            end
        end
        check({tag, "_stall"}, cyc, 5);
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else want = 32'hxxxx_xxxx;
        check({tag, "_rdata"}, rd1, want);
        check({tag, "_addr_lo"}, 32'(a0), 32'(v.exp_a0));
        check({tag, "_addr_hi"}, 32'(alast), 32'(v.exp_a1));
        check({tag, "_we_cycles"}, we_lo, v.exp_we);
        check({tag, "_oe_cycles"}, oe_c, v.exp_oe);
        mr1 = 1'b0; mw1 = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          bad;
        logic [7:0]  we_pat;
        checks = 0; errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        mr1 = 0; mw1 = 0; a1 = '0; wd1 = '0;
        mr2 = 0; mw2 = 0; a2 = '0; wd2 = '0;

        //          rd    wr    tog   addr            wd             exp_rd         a0         a1         we oe
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd1028,       32'h0,         32'h12345678, 18'h00002, 18'h00003, 0, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'd1028,       32'hAABBCCDD, 32'h0,         18'h00002, 18'h00003, 2, 4};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'd1028,       32'h0,         32'hAABBCCDD, 18'h00002, 18'h00003, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd1032,       32'h0F0F1234, 32'h0,         18'h00004, 18'h00005, 2, 4};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'd1032,       32'h0,         32'h0F0F1234, 18'h00004, 18'h00005, 0, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'd1026,       32'h0,         32'h22221111, 18'h00000, 18'h00001, 0, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0008_0408,  32'h55667788, 32'h0,         18'h00004, 18'h00005, 2, 4};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'd1032,       32'h0,         32'h55667788, 18'h00004, 18'h00005, 0, 0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'd1020,       32'h9999AAAA, 32'h0,         18'h3FFFE, 18'h3FFFF, 2, 4};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 32'd1020,       32'h0,         32'h9999AAAA, 18'h3FFFE, 18'h3FFFF, 0, 0};

        #1 rst = 1'b0;
        #2;
        check("reset_ready", rdy1, 1);
        check("reset_rdata", rd1, 0);
        check("reset_addr", 32'(sa1), 0);
        check("reset_dq_o", 32'(dq_o1), 0);
        check("reset_oe", oe1, 0);
        check("reset_we_n", we_n1, 1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run1($sformatf("v%0d", i), vecs[i]);

        // W=2 store: strobe low two cycles per phase, high on each hold cycle.
        @(negedge clk);
        mw2 = 1'b1; a2 = 32'd1024; wd2 = 32'hDEADBEEF;
        #1;
        cyc = 0; we_pat = '0;
        while (!rdy2 && cyc < 50) begin
            if (cyc < 8) we_pat[cyc] = we_n2;
            cyc++;
            @(negedge clk);
            #1;
        end
        check("w2_stall", cyc, 7);
        check("w2_we_pattern", 32'(we_pat), 32'h49);
        check("w2_rdata", rd2, 0);
        mw2 = 1'b0;
        @(negedge clk);
        check("w2_mem_lo", 32'(mem2[0]), 32'h0000BEEF);
        check("w2_mem_hi", 32'(mem2[1]), 32'h0000DEAD);

        // Reset during the HI phase of a write drops the strobe and pads without a clock edge.
        @(negedge clk);
        mw1 = 1'b1; a1 = 32'd1040; wd1 = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        check("hi_we_n_before", we_n1, 0);
        check("hi_oe_before", oe1, 1);
        rst = 1'b0;
        #1;
        check("arst_we_n", we_n1, 1);
        check("arst_oe", oe1, 0);
        check("arst_ready_req", rdy1, 0);
        mw1 = 1'b0;
        #1;
        check("arst_ready_noreq", rdy1, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", rdy1, 1);
        check("post_rst_addr", 32'(sa1), 0);
        check("post_rst_rdata", rd1, 0);
        check("post_rst_we_n", we_n1, 1);
        run1("post_rst_ldr", vecs[0]);

        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!rdy1 || !we_n1 || oe1 || !rdy2 || !we_n2 || oe2) bad++;
        end
        check("idle_transparent", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
